// File: rtl/udp_packet_receiver.sv
// udp_packet_receiver: strips Ethernet/IPv4/UDP headers from 32-bit FIFO words and streams the UDP payload one byte per clock
module udp_packet_receiver (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  rd_flags_i,
    input  logic [31:0] rd_data_i,
    input  logic        rd_src_rdy_i,
    output logic        rd_dst_rdy_o,
    output logic        data_out_en,
    output logic [7:0]  data_out
);
    typedef enum logic [2:0] {IDLE, HEADER, EMIT, PAYLOAD, DROP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  w_q, w_d;
    logic [15:0] plen_q, plen_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        eof_q, eof_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_out_en_q, data_out_en_d;
    logic        accept, sof, eof, hdr_fail;
    logic [2:0]  avail, take;
    assign accept       = rd_src_rdy_i && rd_dst_rdy_o;
    assign sof          = rd_flags_i[0];
    assign eof          = rd_flags_i[1];
    assign rd_dst_rdy_o = state_q != EMIT;
    assign data_out     = data_out_q;
    assign data_out_en  = data_out_en_q;
    // word 10 carries only the last two header-free bytes; later words carry four
    assign avail    = w_q == 4'd10 ? 3'd2 : 3'd4;
    assign take     = plen_q < 16'(avail) ? plen_q[2:0] : avail;
    assign hdr_fail = (w_q == 4'd3 && rd_data_i[31:8] != 24'h080045) ||
                      (w_q == 4'd4 && rd_data_i[31:16] < 16'd28) ||
                      (w_q == 4'd5 && rd_data_i[7:0] != 8'h11);
    // next-state: header parsing, payload latching and byte serialization
    always_comb begin
        state_d       = state_q;
        w_d           = w_q;
        plen_d        = plen_q;
        word_d        = word_q;
        cnt_d         = cnt_q;
        eof_d         = eof_q;
        data_out_d    = data_out_q;
        data_out_en_d = 1'b0;
        if (accept && sof) begin
            w_d     = 4'd1;
            state_d = eof ? IDLE : HEADER;
        end else begin
            case (state_q)
                HEADER: if (accept) begin
                    w_d = w_q + 4'd1;
                    if (w_q == 4'd4) plen_d = rd_data_i[31:16] - 16'd28;
                    if (hdr_fail) state_d = eof ? IDLE : DROP;
                    else if (eof) state_d = IDLE;
                    else if (w_q == 4'd9) state_d = PAYLOAD;
                end
                PAYLOAD: if (accept) begin
                    w_d = 4'd11;
                    if (take == 3'd0) begin
                        state_d = eof ? IDLE : DROP;
                    end else begin
                        state_d = EMIT;
                        cnt_d   = take;
                        plen_d  = plen_q - 16'(take);
                        eof_d   = eof;
                        word_d  = w_q == 4'd10 ? {rd_data_i[15:0], 16'h0000} : rd_data_i;
                    end
                end
                EMIT: begin
                    data_out_d    = word_q[31:24];
                    data_out_en_d = 1'b1;
                    word_d        = {word_q[23:0], 8'h00};
                    cnt_d         = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = eof_q ? IDLE : (plen_q == 16'd0 ? DROP : PAYLOAD);
                end
                DROP: if (accept && eof) state_d = IDLE;
                default: ;
            endcase
        end
    end
    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            w_q           <= '0;
            plen_q        <= '0;
            word_q        <= '0;
            cnt_q         <= '0;
            eof_q         <= 1'b0;
            data_out_q    <= '0;
            data_out_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            plen_q        <= plen_d;
            word_q        <= word_d;
            cnt_q         <= cnt_d;
            eof_q         <= eof_d;
            data_out_q    <= data_out_d;
            data_out_en_q <= data_out_en_d;
        end
    end
endmodule

// File: tb/tb_udp_packet_receiver.sv
// tb_udp_packet_receiver: directed frames with hand-computed payload bytes and ready timing
module tb_udp_packet_receiver;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rd_flags_i = '0;
    logic [31:0] rd_data_i = '0;
    logic        rd_src_rdy_i = 1'b0;
    logic        rd_dst_rdy_o, data_out_en;
    logic [7:0]  data_out;
    int          nvec = 0, nerr = 0, low_cnt = 0;
    logic [7:0]  rx_q[$];

    udp_packet_receiver dut (
        .clk(clk), .reset(reset), .rd_flags_i(rd_flags_i), .rd_data_i(rd_data_i),
        .rd_src_rdy_i(rd_src_rdy_i), .rd_dst_rdy_o(rd_dst_rdy_o),
        .data_out_en(data_out_en), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // collect emitted bytes and count not-ready cycles away from the active edge
    always @(negedge clk) begin
        if (data_out_en) rx_q.push_back(data_out);
        if (!rd_dst_rdy_o) low_cnt++;
    end

    task automatic send(input logic [3:0] f, input logic [31:0] d);
        int t = 0;
        while (!rd_dst_rdy_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            nvec++; nerr++;
            $display("FAIL send_timeout: rd_dst_rdy_o stuck at %0b, required 1", rd_dst_rdy_o);
        end
        rd_flags_i = f; rd_data_i = d; rd_src_rdy_i = 1'b1;
        @(negedge clk);
        rd_src_rdy_i = 1'b0; rd_flags_i = '0;
    endtask

    task automatic send_hdr(input logic [15:0] l, input logic [31:0] w3, input logic [31:0] w5);
        send(4'b0001, 32'h0);
        send(4'b0000, 32'h0);
        send(4'b0000, 32'h0);
        send(4'b0000, w3);
        send(4'b0000, {l, 16'h0000});
        send(4'b0000, w5);
        for (int i = 0; i < 4; i++) send(4'b0000, 32'h0);
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        nvec += 3;
        if (rd_dst_rdy_o !== 1'b1) begin nerr++; $display("FAIL reset_rdy: got %0b, required 1", rd_dst_rdy_o); end
        if (data_out_en !== 1'b0) begin nerr++; $display("FAIL reset_en: got %0b, required 0", data_out_en); end
        if (data_out !== 8'h00) begin nerr++; $display("FAIL reset_data: got %h, required 00", data_out); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_garbage();
        rx_q.delete(); low_cnt = 0;
        send(4'b0001, 32'hffffffff);
        for (int i = 0; i < 100; i++) send(4'b0000, 32'heeeeeeee);
        send(4'b0010, 32'hdddddddd);
        drain();
        nvec += 2;
        if (rx_q.size() != 0) begin nerr++; $display("FAIL garbage_bytes: got %0d, required 0", rx_q.size()); end
        if (low_cnt != 0) begin nerr++; $display("FAIL garbage_rdy_low: got %0d cycles, required 0", low_cnt); end
    endtask

    task automatic test_non_udp();
        rx_q.delete();
        send_hdr(16'h0023, 32'h08004500, 32'heeeeeeee);
        send(4'b0000, 32'hc4804142);
        send(4'b0010, 32'h43444546);
        drain();
        nvec++;
        if (rx_q.size() != 0) begin nerr++; $display("FAIL non_udp_bytes: got %0d, required 0", rx_q.size()); end
    endtask

    task automatic test_short();
        rx_q.delete();
        send_hdr(16'h001c, 32'h08004500, 32'h40004011);
        send(4'b0000, 32'hc4800000);
        for (int i = 0; i < 4; i++) send(i == 3 ? 4'b0010 : 4'b0000, 32'h0);
        drain();
        nvec++;
        if (rx_q.size() != 0) begin nerr++; $display("FAIL zero_len_bytes: got %0d, required 0", rx_q.size()); end
        rx_q.delete();
        send_hdr(16'h001d, 32'h08004500, 32'h40004011);
        send(4'b0000, 32'hc4804100);
        send(4'b0010, 32'h0);
        drain();
        nvec += 2;
        if (rx_q.size() != 1) begin nerr++; $display("FAIL one_byte_count: got %0d, required 1", rx_q.size()); end
        else if (rx_q[0] !== 8'h41) begin nerr++; $display("FAIL one_byte_value: got %h, required 41", rx_q[0]); end
        if (rx_q.size() == 1 && rx_q[0] === 8'h41) ;
    endtask

    task automatic test_multi_word();
        int lo[3];
        logic [31:0] w[3];
        w[0] = 32'hc4804142; w[1] = 32'h43444546; w[2] = 32'h47000000;
        rx_q.delete();
        send_hdr(16'h0023, 32'h08004500, 32'h40004011);
        for (int k = 0; k < 3; k++) begin
            send(4'b0000, w[k]);
            lo[k] = 0;
            while (!rd_dst_rdy_o && lo[k] < 20) begin
                lo[k]++;
                @(negedge clk);
            end
        end
        send(4'b0010, 32'h12345678);
        drain();
        nvec += 4;
        if (lo[0] != 2) begin nerr++; $display("FAIL rdy_low_w10: got %0d, required 2", lo[0]); end
        if (lo[1] != 4) begin nerr++; $display("FAIL rdy_low_w11: got %0d, required 4", lo[1]); end
        if (lo[2] != 1) begin nerr++; $display("FAIL rdy_low_w12: got %0d, required 1", lo[2]); end
        if (rx_q.size() != 7) begin nerr++; $display("FAIL multi_count: got %0d, required 7", rx_q.size()); end
        for (int i = 0; i < 7 && i < rx_q.size(); i++) begin
            nvec++;
            if (rx_q[i] !== 8'(8'h41 + i)) begin nerr++; $display("FAIL multi_byte%0d: got %h, required %h", i, rx_q[i], 8'(8'h41 + i)); end
        end
    endtask

    task automatic test_long();
        int bad = 0;
        logic [7:0] exp;
        rx_q.delete();
        send_hdr(16'h03ea, 32'h08004500, 32'h40004011);
        send(4'b0000, 32'h00004142);
        for (int i = 0; i < 243; i++) send(i == 242 ? 4'b0110 : 4'b0000, 32'h43444546);
        drain();
        nvec += 3;
        if (rx_q.size() != 974) begin nerr++; $display("FAIL long_count: got %0d, required 974", rx_q.size()); end
        for (int i = 0; i < rx_q.size(); i++) begin
            exp = i == 0 ? 8'h41 : i == 1 ? 8'h42 : 8'(8'h43 + (i - 2) % 4);
            if (rx_q[i] !== exp) bad++;
        end
        if (bad != 0) begin nerr++; $display("FAIL long_content: got %0d wrong bytes, required 0", bad); end
        rx_q.delete();
        send(4'b0000, 32'h08004500);
        drain();
        if (rx_q.size() != 0 || rd_dst_rdy_o !== 1'b1) begin
            nerr++; $display("FAIL long_idle: got %0d bytes rdy %0b, required 0 bytes rdy 1", rx_q.size(), rd_dst_rdy_o);
        end
    endtask

    task automatic test_reset_mid();
        rx_q.delete();
        send_hdr(16'h0023, 32'h08004500, 32'h40004011);
        send(4'b0000, 32'hc4804142);
        @(posedge clk);
        #2;
        nvec += 5;
        if (data_out_en !== 1'b1 || data_out !== 8'h41) begin
            nerr++; $display("FAIL mid_first_byte: got en %0b data %h, required en 1 data 41", data_out_en, data_out);
        end
        reset = 1'b0;
        #1;
        if (rd_dst_rdy_o !== 1'b1) begin nerr++; $display("FAIL mid_reset_rdy: got %0b, required 1", rd_dst_rdy_o); end
        if (data_out_en !== 1'b0) begin nerr++; $display("FAIL mid_reset_en: got %0b, required 0", data_out_en); end
        if (data_out !== 8'h00) begin nerr++; $display("FAIL mid_reset_data: got %h, required 00", data_out); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rx_q.delete();
        send(4'b0000, 32'h43444546);
        send(4'b0010, 32'h47000000);
        send_hdr(16'h001d, 32'h08004500, 32'h40004011);
        send(4'b0000, 32'hc4805a00);
        send(4'b0010, 32'h0);
        drain();
        if (rx_q.size() != 1 || rx_q[0] !== 8'h5a) begin
            nerr++; $display("FAIL mid_new_frame: got %0d bytes first %h, required 1 byte 5a", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_garbage();
        test_non_udp();
        test_short();
        test_multi_word();
        test_long();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/udp_packet_receiver.md
# udp_packet_receiver

Parses Ethernet/IPv4/UDP frames arriving as 32-bit words from a receive FIFO and streams only the UDP payload out one byte per clock. It sits between the Ethernet MAC RX FIFO (LocalLink-style 32-bit read port with SOF/EOF flags) and byte-wide downstream consumers. Non-IPv4 and non-UDP frames, link padding and trailing bytes are discarded.

## Interface
Parameters:
- none.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rd_flags_i  input  4  bit0 SOF, bit1 EOF, bits[3:2] last-word occupancy (ignored by this block).
- rd_data_i  input  32  frame word; byte order big-endian (first wire byte in [31:24]).
- rd_src_rdy_i  input  1  FIFO has a valid word.
- rd_dst_rdy_o  output  1  block can accept a word; transfer when rd_src_rdy_i && rd_dst_rdy_o on a rising edge.
- data_out_en  output  1  data_out valid this cycle (one byte per asserted cycle).
- data_out  output  8  payload byte.

## Operation
- Frame begins directly at destination MAC (no preamble). Word index w counts accepted words; SOF word is w=0.
- Header checks: w=3 must be 0x0800_45xx (EtherType IPv4, version 4, IHL 5); w=4[31:16] = IP total length L; w=5[7:0] must be 0x11 (UDP). MAC, IP addresses, ports, checksums, TTL, fragment fields not checked.
- Payload length P = L − 28 (16-bit). If L < 28 frame is dropped.
- Payload starts at w=10 bytes [15:8],[7:0]; then w≥11 all four bytes MSB-first. Exactly P bytes emitted; remaining bytes/words (padding, FCS) discarded.
- States: IDLE (wait SOF word), HEADER (w=1..9, check fields), EMIT (serialize bytes of latched word), PAYLOAD (wait next payload word), DROP (consume words until EOF).
- Transitions: any check failure → DROP; P reached → DROP, or IDLE if the current word carried EOF; EOF before P reached → IDLE (partial payload already emitted stands); EOF in DROP → IDLE.
- Any accepted word with SOF set restarts parsing at w=0 regardless of state.
- Words accepted in IDLE without SOF are discarded.

## Timing
- Reset values: rd_dst_rdy_o=1, data_out_en=0, data_out=0x00, state IDLE, counters 0.
- rd_dst_rdy_o=1 in IDLE, HEADER, PAYLOAD, DROP; 0 in EMIT. Header and dropped words accepted at one word per clock.
- data_out/data_out_en registered. Accepting a word with n payload bytes (n=1..4) on edge t: bytes appear after edges t+1..t+n, data_out_en high n consecutive cycles, no gaps; rd_dst_rdy_o low from t until edge t+n, high again after edge t+n.
- Full-payload word throughput: 5 cycles per word (1 accept + 4 emit).
- data_out_en low in all non-emitting cycles; data_out holds last byte.
- Asynchronous reset mid-frame: outputs to reset values immediately; rest of that frame treated as non-SOF words (discarded) until next SOF.

## Test plan
- Garbage frame: SOF 0xffffffff, 100× 0xeeeeeeee, EOF 0xdddddddd → no data_out_en, rd_dst_rdy_o stays 1.
- IPv4 non-UDP: w=3 0x08004500, w=5 0xeeeeeeee → no output.
- UDP, L=0x001c, w=10 0xc4800000 plus 4 zero padding words → no output; L=0x001d, w=10 0xc4804100 → single byte 0x41.
- UDP L=0x0023, w=10 0xc4804142, w=11 0x43444546, w=12 0x47000000 → bytes 0x41..0x47 in order, then nothing; rd_dst_rdy_o low 2,4,1 cycles respectively.
- Long frame L=0x03ea, w=10 0x00004142, 243 words 0x43444546 (last with EOF, occupancy 01) → 974 bytes: 0x41,0x42, then 0x43,0x44,0x45,0x46 repeated; returns to IDLE.
- Reset asserted during EMIT, then new valid frame → outputs cleared immediately, new frame payload emitted correctly.
